// File: rtl/issue_queue_flush_returner.sv
// Walks a flushed-entry mask chunk by chunk, handing freed issue-queue indices back
// RETURN_WIDTH at a time; flushes arriving mid-walk are merged into the pending mask.
module issue_queue_flush_returner #(
  parameter int ENTRY_NUM    = 16,
  parameter int RETURN_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flushReq,
  input  logic [ENTRY_NUM-1:0]                        flushMask,
  output logic [RETURN_WIDTH-1:0]                     returnValid,
  output logic [RETURN_WIDTH*$clog2(ENTRY_NUM)-1:0]   returnIndex,
  output logic                                        busy,
  output logic                                        done
);

  localparam int CYCLE_NUM = (ENTRY_NUM - 1) / RETURN_WIDTH + 1;
  localparam int IDX_W     = $clog2(ENTRY_NUM);
  localparam int CNT_W     = (CYCLE_NUM > 1) ? $clog2(CYCLE_NUM) : 1;
  // Pending mask zero-padded to a whole number of chunks so the last chunk's
  // out-of-range lanes read as invalid.
  localparam int EXT_W     = CYCLE_NUM * RETURN_WIDTH;

  typedef enum logic {S_IDLE, S_RETURN} state_t;

  state_t                  r_state;
  logic [ENTRY_NUM-1:0]    r_pend;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_done;

  logic [31:0]             w_base;
  logic [EXT_W-1:0]        w_pend_ext;
  logic [RETURN_WIDTH-1:0] w_chunk;
  logic [RETURN_WIDTH-1:0] w_valid;
  logic [ENTRY_NUM-1:0]    w_clr;
  logic [ENTRY_NUM-1:0]    w_pend_next;
  logic [CNT_W-1:0]        w_cnt_next;

  assign w_base      = 32'(r_cnt) * 32'(RETURN_WIDTH);
  assign w_pend_ext  = EXT_W'(r_pend);
  assign w_chunk     = RETURN_WIDTH'(w_pend_ext >> w_base);
  assign w_valid     = (r_state == S_RETURN) ? w_chunk : '0;
  assign w_clr       = ENTRY_NUM'(EXT_W'(w_valid) << w_base);
  assign w_pend_next = (r_pend & ~w_clr) | (flushReq ? flushMask : '0);
  assign w_cnt_next  = (r_cnt == CNT_W'(CYCLE_NUM - 1)) ? '0 : r_cnt + CNT_W'(1);

  // Lane indices depend only on the registered chunk counter.
  generate
    for (genvar gi = 0; gi < RETURN_WIDTH; gi++) begin : g_lane
      assign returnIndex[gi*IDX_W +: IDX_W] = w_base[IDX_W-1:0] + IDX_W'(gi);
    end
  endgenerate

  assign returnValid = w_valid;
  assign busy        = (r_state == S_RETURN);
  assign done        = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flushReq) begin
            if (|flushMask) begin
              r_pend  <= flushMask;
              r_cnt   <= '0;
              r_state <= S_RETURN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RETURN: begin
          r_pend <= w_pend_next;
          r_cnt  <= w_cnt_next;
          if (w_pend_next == '0) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_queue_flush_returner.sv
// Scoreboard bench: directed flushes push expected (cycle, index/done) events; monitors
// pop and compare whenever a DUT presents a valid lane or a done pulse.
module tb_issue_queue_flush_returner;

  typedef struct {
    int cyc;
    int val;   // freed index, or -1 for the done pulse
  } exp_t;

  logic        clk;
  logic        rst;
  logic        a_req, b_req;
  logic [15:0] a_mask;
  logic [7:0]  b_mask;
  logic [3:0]  a_valid;
  logic [15:0] a_index;
  logic        a_busy, a_done;
  logic [2:0]  b_valid;
  logic [8:0]  b_index;
  logic        b_busy, b_done;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  issue_queue_flush_returner #(.ENTRY_NUM(16), .RETURN_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .flushReq(a_req), .flushMask(a_mask),
    .returnValid(a_valid), .returnIndex(a_index), .busy(a_busy), .done(a_done)
  );

  issue_queue_flush_returner #(.ENTRY_NUM(8), .RETURN_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst), .flushReq(b_req), .flushMask(b_mask),
    .returnValid(b_valid), .returnIndex(b_index), .busy(b_busy), .done(b_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_a(input int c, input int v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input int v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    qb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    a_req = 0;
    b_req = 0;
  endtask

  // Monitor for the 16-entry / 4-lane instance
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      for (int l = 0; l < 4; l++) begin
        if (a_valid[l]) begin
          if (qa.size() == 0) chk("A unexpected return", int'(a_index[l*4 +: 4]), -2);
          else begin
            e = qa.pop_front();
            chk("A return value", int'(a_index[l*4 +: 4]), e.val);
            chk("A return cycle", cyc, e.cyc);
          end
        end
      end
      if (a_done) begin
        chk("A done with valid", int'(|a_valid), 0);
        if (qa.size() == 0) chk("A unexpected done", -1, -2);
        else begin
          e = qa.pop_front();
          chk("A done value", -1, e.val);
          chk("A done cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Monitor for the 8-entry / 3-lane instance
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      for (int l = 0; l < 3; l++) begin
        if (b_valid[l]) begin
          if (qb.size() == 0) chk("B unexpected return", int'(b_index[l*3 +: 3]), -2);
          else begin
            e = qb.pop_front();
            chk("B return value", int'(b_index[l*3 +: 3]), e.val);
            chk("B return cycle", cyc, e.cyc);
          end
        end
      end
      if (b_done) begin
        chk("B done with valid", int'(|b_valid), 0);
        if (qb.size() == 0) chk("B unexpected done", -1, -2);
        else begin
          e = qb.pop_front();
          chk("B done value", -1, e.val);
          chk("B done cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int t0;
    rst = 1; a_req = 0; b_req = 0; a_mask = '0; b_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    step();
    mon_en = 1;
    chk("reset A valid", int'(a_valid), 0);
    chk("reset A busy",  int'(a_busy), 0);
    chk("reset A done",  int'(a_done), 0);
    chk("reset B valid", int'(b_valid), 0);
    chk("reset B busy",  int'(b_busy), 0);

    // 0x8421 on A, diagonal pattern; concurrently 0xFF on the 8/3 instance
    t0 = cyc;
    a_req = 1; a_mask = 16'h8421;
    b_req = 1; b_mask = 8'hFF;
    push_a(t0+1, 0); push_a(t0+2, 5); push_a(t0+3, 10); push_a(t0+4, 15); push_a(t0+5, -1);
    push_b(t0+1, 0); push_b(t0+1, 1); push_b(t0+1, 2);
    push_b(t0+2, 3); push_b(t0+2, 4); push_b(t0+2, 5);
    push_b(t0+3, 6); push_b(t0+3, 7); push_b(t0+4, -1);
    $display("txn: A flush 0x8421, B flush 0xFF at cycle %0d", t0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("A busy during return", int'(a_busy), 1);
      if (k == 3) chk("B last chunk lanes", int'(b_valid), 3);
    end
    step();
    chk("A busy after done", int'(a_busy), 0);
    step();

    // Empty mask: done only
    t0 = cyc;
    a_req = 1; a_mask = 16'h0000;
    push_a(t0+1, -1);
    $display("txn: A flush 0x0000 at cycle %0d", t0);
    step();
    chk("A busy on empty flush", int'(a_busy), 0);
    step();

    // Full first chunk
    t0 = cyc;
    a_req = 1; a_mask = 16'h000F;
    for (int i = 0; i < 4; i++) push_a(t0+1, i);
    push_a(t0+2, -1);
    $display("txn: A flush 0x000F at cycle %0d", t0);
    step();
    chk("A chunk0 all valid", int'(a_valid), 15);
    repeat (2) step();

    // Merge with wrap-around
    t0 = cyc;
    a_req = 1; a_mask = 16'hF000;
    for (int i = 12; i < 16; i++) push_a(t0+4, i);
    push_a(t0+5, 0); push_a(t0+5, 1); push_a(t0+6, -1);
    $display("txn: A flush 0xF000 then merge 0x0003 at cycle %0d", t0);
    step();
    step();
    a_req = 1; a_mask = 16'h0003;
    repeat (5) step();

    // Reset mid-return, with a flushReq in the reset cycle that must be ignored
    t0 = cyc;
    a_req = 1; a_mask = 16'hFFFF;
    for (int i = 0; i < 4; i++) push_a(t0+1, i);
    for (int i = 4; i < 8; i++) push_a(t0+2, i);
    $display("txn: A flush 0xFFFF with reset at cycle %0d", t0+2);
    step();
    step();
    rst = 1; a_req = 1; a_mask = 16'h0001;
    step();
    rst = 0;
    chk("A busy after reset",  int'(a_busy), 0);
    chk("A valid after reset", int'(a_valid), 0);
    chk("A done after reset",  int'(a_done), 0);
    t0 = cyc;
    a_req = 1; a_mask = 16'h0010;
    push_a(t0+2, 4); push_a(t0+3, -1);
    $display("txn: A flush 0x0010 after reset at cycle %0d", t0);
    repeat (4) step();

    // Index re-flushed right as it is returned comes back once more after the wrap
    t0 = cyc;
    a_req = 1; a_mask = 16'h0001;
    push_a(t0+1, 0); push_a(t0+5, 0); push_a(t0+6, -1);
    $display("txn: A flush 0x0001 re-flushed at cycle %0d", t0+1);
    step();
    a_req = 1; a_mask = 16'h0001;
    repeat (7) step();

    chk("A scoreboard drained", qa.size(), 0);
    chk("B scoreboard drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_flush_returner.md
ISSUE_QUEUE_FLUSH_RETURNER -- requirements
Module: issue_queue_flush_returner

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 16: issue-queue entry count, power of two, at least 2.
REQ-002 SHALL have parameter RETURN_WIDTH, default 4: freed indices returned per cycle, 1..ENTRY_NUM.
REQ-003 SHALL derive CYCLE_NUM = (ENTRY_NUM-1)/RETURN_WIDTH+1, IDX_W = $clog2(ENTRY_NUM) and CNT_W = max(1, $clog2(CYCLE_NUM)).
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flushReq, input, 1: single-cycle request to flush the entries in flushMask.
REQ-007 SHALL have port flushMask, input, ENTRY_NUM: bit i set means entry i is flushed; sampled only when flushReq=1.
REQ-008 SHALL have port returnValid, output, RETURN_WIDTH: lane i carries a valid freed index.
REQ-009 SHALL have port returnIndex, output, RETURN_WIDTH x IDX_W: freed issue-queue index per lane.
REQ-010 SHALL have port busy, output, 1: return sequence in progress; dispatch to the issue queue is stalled while busy=1.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking completion of a flush.

Function
REQ-012 SHALL keep a pending mask P[ENTRY_NUM], a chunk counter C[CNT_W] and a two-state FSM: IDLE or RETURN.
REQ-013 IDLE, flushReq=1, flushMask!=0: next cycle P=flushMask, C=0, state RETURN.
REQ-014 IDLE, flushReq=1, flushMask==0: state stays IDLE; done=1 next cycle; returnValid stays 0.
REQ-015 RETURN: lane i drives index C*RETURN_WIDTH+i; returnValid[i]=P[C*RETURN_WIDTH+i]; lanes with index >= ENTRY_NUM drive returnValid=0.
REQ-016 RETURN: every bit driven valid this cycle is cleared in P at the clock edge.
REQ-017 RETURN: C increments each cycle and wraps from CYCLE_NUM-1 to 0.
REQ-018 RETURN: when P with the current chunk cleared is zero and no flushReq is accepted, the next state is IDLE and done=1 in that next cycle.
REQ-019 Merge rule: flushReq=1 while in RETURN ORs flushMask into P after the current chunk is cleared; C is not reset; wrap-around picks up bits in earlier chunks.
REQ-020 Any index set in a merged mask that is still pending is returned exactly once; an index already returned and then set again in a later mask is returned again.
REQ-021 Latency: the first returns appear one cycle after an accepted flushReq; a single flush completes within CYCLE_NUM cycles.
REQ-022 Every returnIndex lane SHALL be registered or derived only from registered C; lanes with returnValid=0 drive don't-care values, which the bench does not check.
REQ-023 busy=1 exactly when the state is RETURN.
REQ-024 done is high for one cycle only and never in the same cycle as a nonzero returnValid.

Reset
REQ-025 rst=1 SHALL set state IDLE, P=0, C=0, busy=0, done=0 and returnValid=0 at the next edge.
REQ-026 rst during RETURN SHALL abandon remaining returns with no done pulse; a flushReq in the reset cycle is ignored.
REQ-027 All outputs SHALL be 0 in the first cycle after reset deasserts.

Verification
REQ-028 ENTRY_NUM=16, RETURN_WIDTH=4, flushMask=0x8421 at t0 -> return index 0 at t1, index 5 at t2, index 10 at t3, index 15 at t4; done at t5; busy high t1..t4.
REQ-029 flushMask=0x0000 at t0 -> no returnValid; done at t1; busy never 1.
REQ-030 flushMask=0x000F at t0 -> indices 0..3 valid at t1; done at t2.
REQ-031 flushMask=0xF000 at t0 with a second flushReq of 0x0003 at t2 -> indices 12..15 at t4; C wraps; indices 0,1 at t5; done at t6; each index returned once.
REQ-032 ENTRY_NUM=8, RETURN_WIDTH=3, flushMask=0xFF -> 3, 3 and 2 valid lanes over 3 cycles; lane 2 of the last chunk stays invalid.
REQ-033 flushMask=0xFFFF at t0 with rst at t2 -> busy=0 and returnValid=0 at t3; no done; next flushReq behaves as from IDLE.
